// File: rtl/cnt_rr_sched_pkg.sv
// ---------------------------------------------------------------------------
// cnt_rr_sched_pkg : shared types and width helpers for cnt_rr_sched
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cnt_rr_sched_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // hold_cnt has to represent the value HOLD itself
  function automatic int hold_w(input int h);
    return (h > 1) ? $clog2(h + 1) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cnt_rr_sched_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : combinational round-robin selector, first request at/after ptr
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import cnt_rr_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] pick_o,
  output logic [IW-1:0]   idx_o
);

  logic [2*NREQ-1:0] w_req2;
  logic [2*NREQ-1:0] w_pick2;
  logic [NREQ-1:0]   w_pick_rot;
  logic [IW-1:0]     w_ofs;
  logic [IW:0]       w_sum;
  logic              w_found;

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    w_req2     = {req_i, req_i} >> ptr_i;
    w_found    = 1'b0;
    w_ofs      = '0;
    w_pick_rot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && w_req2[i]) begin
        w_found       = 1'b1;
        w_ofs         = IW'(i);
        w_pick_rot[i] = 1'b1;
      end
    end
    w_pick2 = {w_pick_rot, w_pick_rot} << ptr_i;
    pick_o  = w_pick2[2*NREQ-1:NREQ];
    w_sum   = {1'b0, ptr_i} + {1'b0, w_ofs};
    if (w_sum >= (IW+1)'(NREQ)) begin
      w_sum = w_sum - (IW+1)'(NREQ);
    end
    idx_o = w_sum[IW-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/cnt_rr_sched.sv
// ---------------------------------------------------------------------------
// cnt_rr_sched : round-robin access scheduler for one shared event counter
// Build option CNT_RR_SCHED_SAT_EN: saturate at all-ones instead of wrapping.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cnt_rr_sched
  import cnt_rr_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CW   = 4,
  parameter int HOLD = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] inc,
  input  logic            clr,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_vld,
  output logic [CW-1:0]   cnt,
  output logic            full,
  output logic            empty,
  output logic            ovf
);

  localparam int IW = idx_w(NREQ);
  localparam int HW = hold_w(HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD);

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            gnt_vld_q, gnt_vld_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  logic [NREQ-1:0] w_pick;
  logic [IW-1:0]   w_pick_idx;
  logic            w_release;
  logic            w_inc;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .pick_o (w_pick),
    .idx_o  (w_pick_idx)
  );

  // A tenure is capped at HOLD granted cycles, or ends early when req drops.
  assign w_release = !req[gidx_q] || (hold_q == HOLD_LAST);
  assign w_inc     = gnt_vld_q & inc[gidx_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|req) begin
          gnt_d   = w_pick;
          gidx_d  = w_pick_idx;
          hold_d  = HW'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (w_release) begin
          gnt_d   = '0;
          hold_d  = '0;
          ptr_d   = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
          state_d = IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    gnt_vld_d = |gnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (w_inc) begin
      if (cnt_q == {CW{1'b1}}) begin
        ovf_d = 1'b1;
`ifdef CNT_RR_SCHED_SAT_EN
        cnt_d = cnt_q;
`else
        cnt_d = '0;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_vld_q <= gnt_vld_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = gnt_vld_q;
  assign cnt     = cnt_q;
  assign full    = (cnt_q == {CW{1'b1}});
  assign empty   = (cnt_q == '0);
  assign ovf     = ovf_q;

endmodule

`default_nettype wire
